// File: rtl/nq_sram_pkg.sv
// nq_sram_pkg: shared types and constants for the asynchronous-SRAM
// controller that sits between the CPU external memory port and a
// 16-bit word-organised SRAM.
//   - sram_state_t : controller FSM states
//   - WAIT_CNT_W   : width of the shared wait-state down counter
//   - bus widths   : CPU byte address, SRAM word address, data
//   - wait_preload : counter preload for a given number of wait cycles
package nq_sram_pkg;

  localparam int WAIT_CNT_W  = 4;
  localparam int WAIT_MIN    = 32'sd1;
  localparam int WAIT_MAX    = (32'sd1 <<< WAIT_CNT_W) - 32'sd1;
  localparam int CPU_ADDR_W  = 16;
  localparam int SRAM_ADDR_W = 15;
  localparam int DATA_W      = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    WR     = 3'd2,
    WR_REC = 3'd3,
    DONE   = 3'd4
  } sram_state_t;

  // The counter runs from WAIT-1 down to zero, so a state that leaves on
  // the zero flag stays exactly WAIT cycles.
  function automatic logic [WAIT_CNT_W-1:0] wait_preload(input int unsigned wait_cycles);
    logic [WAIT_CNT_W-1:0] w;
    w = wait_cycles[WAIT_CNT_W-1:0];
    return w - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/nq_wait_counter.sv
// nq_wait_counter: loadable down counter used to time SRAM strobes.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load_i      : load load_val_i (has priority over en_i)
//   load_val_i  : preload value
//   en_i        : decrement by one (saturates at zero)
//   zero_o      : count is zero
module nq_wait_counter
  import nq_sram_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [WAIT_CNT_W-1:0] load_val_i,
  input  logic                  en_i,
  output logic                  zero_o
);

  logic [WAIT_CNT_W-1:0] cnt_q;
  logic [WAIT_CNT_W-1:0] cnt_d;

  // Next count: load wins, otherwise decrement while enabled and non-zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != {WAIT_CNT_W{1'b0}})) begin
      cnt_d = cnt_q - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {WAIT_CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {WAIT_CNT_W{1'b0}});

endmodule

// File: rtl/nq_sram_ctl.sv
// nq_sram_ctl: converts single-cycle CPU memory requests into timed
// asynchronous-SRAM cycles and stalls the CPU until they complete.
// Ports:
//   clk, rst_n      : system clock, asynchronous active-low reset
//   cpu_addr_i      : CPU byte address (bit 0 ignored)
//   cpu_re_i        : CPU read request
//   cpu_we_i        : CPU write request (wins over read)
//   cpu_data_io     : CPU data bus, driven only in DONE of a read
//   cpu_needWait_o  : stall, combinational from request and state
//   sram_addr_o     : latched SRAM word address
//   sram_ce_n_o     : SRAM chip enable (active low)
//   sram_oe_n_o     : SRAM output enable (active low)
//   sram_we_n_o     : SRAM write enable (active low)
//   sram_dq_io      : SRAM data bus, driven in WR and WR_REC
//   err_o           : sticky, read and write requested together
// Parameters:
//   READ_WAIT       : cycles with oe_n low before data capture (1..15)
//   WRITE_WAIT      : cycles with we_n low per write (1..15)
module nq_sram_ctl
  import nq_sram_pkg::*;
#(
  parameter int READ_WAIT  = 2,
  parameter int WRITE_WAIT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [CPU_ADDR_W-1:0]  cpu_addr_i,
  input  logic                   cpu_re_i,
  input  logic                   cpu_we_i,
  inout  wire  [DATA_W-1:0]      cpu_data_io,
  output logic                   cpu_needWait_o,
  output logic [SRAM_ADDR_W-1:0] sram_addr_o,
  output logic                   sram_ce_n_o,
  output logic                   sram_oe_n_o,
  output logic                   sram_we_n_o,
  inout  wire  [DATA_W-1:0]      sram_dq_io,
  output logic                   err_o
);

  generate
    if ((READ_WAIT < WAIT_MIN) || (READ_WAIT > WAIT_MAX) ||
        (WRITE_WAIT < WAIT_MIN) || (WRITE_WAIT > WAIT_MAX)) begin : g_bad_wait
      $error("nq_sram_ctl: READ_WAIT and WRITE_WAIT must be within 1..15");
    end
  endgenerate

  localparam logic [WAIT_CNT_W-1:0] RD_PRELOAD = wait_preload(READ_WAIT);
  localparam logic [WAIT_CNT_W-1:0] WR_PRELOAD = wait_preload(WRITE_WAIT);

  sram_state_t            state_q;
  sram_state_t            state_d;

  logic [SRAM_ADDR_W-1:0] addr_q,    addr_d;
  logic [DATA_W-1:0]      wr_data_q, wr_data_d;
  logic [DATA_W-1:0]      rd_data_q, rd_data_d;
  logic                   is_rd_q,   is_rd_d;
  logic                   err_q,     err_d;
  logic                   ce_n_q,    ce_n_d;
  logic                   oe_n_q,    oe_n_d;
  logic                   we_n_q,    we_n_d;
  logic                   dq_oe_q,   dq_oe_d;

  logic                   req_s;
  logic                   cnt_load_s;
  logic                   cnt_en_s;
  logic [WAIT_CNT_W-1:0]  cnt_val_s;
  logic                   cnt_zero_s;
  logic                   cpu_drv_s;
  logic                   unused_addr_lsb_s;

  assign req_s             = cpu_re_i | cpu_we_i;
  assign unused_addr_lsb_s = cpu_addr_i[0];

  // One counter serves both the read and the write strobe phase.
  assign cnt_load_s = (state_q == IDLE) & req_s;
  assign cnt_en_s   = (state_q == RD) | (state_q == WR);
  assign cnt_val_s  = cpu_we_i ? WR_PRELOAD : RD_PRELOAD;

  nq_wait_counter u_wait_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load_s),
    .load_val_i (cnt_val_s),
    .en_i       (cnt_en_s),
    .zero_o     (cnt_zero_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state. A dropped read aborts; a started write always finishes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = cpu_we_i ? WR : RD;
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        if (!cpu_re_i) begin
          state_d = IDLE;
        end else if (cnt_zero_s) begin
          state_d = DONE;
        end else begin
          state_d = RD;
        end
      end
      WR: begin
        if (cnt_zero_s) begin
          state_d = WR_REC;
        end else begin
          state_d = WR;
        end
      end
      WR_REC:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from the next state so the registered strobes
  // line up with the state they belong to. WR_REC keeps dq driven with
  // we_n high to give the SRAM data hold after the write pulse.
  always_comb begin
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    case (state_d)
      IDLE: begin
        ce_n_d = 1'b1;
      end
      RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
      end
      WR: begin
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      WR_REC: begin
        ce_n_d  = 1'b0;
        dq_oe_d = 1'b1;
      end
      DONE: begin
        ce_n_d = 1'b1;
      end
      default: begin
        ce_n_d = 1'b1;
      end
    endcase
  end

  // Datapath next values: latch address/write data when an access starts,
  // capture read data only on the final RD cycle with the read still held.
  always_comb begin
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    rd_data_d = rd_data_q;
    is_rd_d   = is_rd_q;
    if ((state_q == IDLE) && req_s) begin
      addr_d    = cpu_addr_i[CPU_ADDR_W-1:1];
      wr_data_d = cpu_data_io;
      is_rd_d   = ~cpu_we_i;
    end else if ((state_q == RD) && cpu_re_i && cnt_zero_s) begin
      rd_data_d = sram_dq_io;
    end else begin
      rd_data_d = rd_data_q;
    end
  end

  assign err_d = err_q | (cpu_re_i & cpu_we_i);

  // Datapath and strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= {SRAM_ADDR_W{1'b0}};
      wr_data_q <= {DATA_W{1'b0}};
      rd_data_q <= {DATA_W{1'b0}};
      is_rd_q   <= 1'b0;
      err_q     <= 1'b0;
      ce_n_q    <= 1'b1;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      dq_oe_q   <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      rd_data_q <= rd_data_d;
      is_rd_q   <= is_rd_d;
      err_q     <= err_d;
      ce_n_q    <= ce_n_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      dq_oe_q   <= dq_oe_d;
    end
  end

  // The stall must rise in the same cycle a request appears.
  assign cpu_needWait_o = req_s & (state_q != DONE);

  assign cpu_drv_s   = (state_q == DONE) & is_rd_q & cpu_re_i;
  assign cpu_data_io = cpu_drv_s ? rd_data_q : {DATA_W{1'bz}};
  assign sram_dq_io  = dq_oe_q ? wr_data_q : {DATA_W{1'bz}};

  assign sram_addr_o = addr_q;
  assign sram_ce_n_o = ce_n_q;
  assign sram_oe_n_o = oe_n_q;
  assign sram_we_n_o = we_n_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_nq_sram_ctl.sv
// Bench for nq_sram_ctl with READ_WAIT = WRITE_WAIT = 2. A timeline model
// derives the expected bus activity from the start cycle of each access.
module tb_nq_sram_ctl;

  localparam int R = 2;
  localparam int W = 2;

  logic        clk;
  logic        rst_n;
  logic [15:0] cpu_addr;
  logic        cpu_re;
  logic        cpu_we;
  wire  [15:0] cpu_data;
  logic        nw;
  logic [14:0] sram_addr;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  wire  [15:0] sram_dq;
  logic        err;

  logic        tb_drv;
  logic [15:0] tb_data;
  logic [15:0] mem [0:32767];

  int          checks;
  int          errors;
  int unsigned cyc;
  int unsigned wel_cnt;

  logic        m_busy;
  logic        m_is_wr;
  logic        m_err;
  int unsigned m_start;
  logic [14:0] m_waddr;
  logic [15:0] m_wdata;

  assign cpu_data = tb_drv ? tb_data : 16'hzzzz;
  assign sram_dq  = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'hzzzz;

  nq_sram_ctl #(.READ_WAIT(R), .WRITE_WAIT(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cpu_addr_i     (cpu_addr),
    .cpu_re_i       (cpu_re),
    .cpu_we_i       (cpu_we),
    .cpu_data_io    (cpu_data),
    .cpu_needWait_o (nw),
    .sram_addr_o    (sram_addr),
    .sram_ce_n_o    (sram_ce_n),
    .sram_oe_n_o    (sram_oe_n),
    .sram_we_n_o    (sram_we_n),
    .sram_dq_io     (sram_dq),
    .err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic mdl_reset();
    m_busy = 1'b0;
    m_err  = 1'b0;
  endtask

  // Expected outputs for the current cycle, from the access start cycle:
  // read  : d=0 request, d=1..R strobes (abort if re low), d=R+1 done
  // write : d=0 request, d=1..W we_n low, d=W+1 hold, d=W+2 done
  task automatic model_cmp();
    logic        req;
    logic        e_nw, e_ce, e_oe, e_we;
    logic        c_addr, c_dq, c_cpu;
    logic [15:0] e_cpu;
    int unsigned d;
    req = cpu_re | cpu_we;
    if (!rst_n) begin
      mdl_reset();
      chk("rst_needwait", 32'(nw), 32'(req));
      chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
      chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
    end else begin
      if (!m_busy && req) begin
        m_busy  = 1'b1;
        m_is_wr = cpu_we;
        m_start = cyc;
        m_waddr = cpu_addr[15:1];
        m_wdata = cpu_data;
      end
      e_nw = req; e_ce = 1'b1; e_oe = 1'b1; e_we = 1'b1;
      c_addr = 1'b0; c_dq = 1'b0; c_cpu = 1'b0; e_cpu = 16'h0000;
      if (m_busy) begin
        d = cyc - m_start;
        if (m_is_wr) begin
          if (d >= 1 && d <= W) begin
            e_ce = 1'b0; e_we = 1'b0; c_dq = 1'b1; c_addr = 1'b1;
          end else if (d == W + 1) begin
            e_ce = 1'b0; c_dq = 1'b1; c_addr = 1'b1;
          end else if (d == W + 2) begin
            e_nw = 1'b0; c_addr = 1'b1; m_busy = 1'b0;
          end
        end else begin
          if (d >= 1 && d <= R) begin
            e_ce = 1'b0; e_oe = 1'b0; c_addr = 1'b1;
            if (!cpu_re) m_busy = 1'b0;
          end else if (d == R + 1) begin
            e_nw = 1'b0; c_addr = 1'b1; c_cpu = cpu_re;
            e_cpu = mem[m_waddr]; m_busy = 1'b0;
          end
        end
      end
      chk("needwait", 32'(nw), 32'(e_nw));
      chk("ce_n", 32'(sram_ce_n), 32'(e_ce));
      chk("oe_n", 32'(sram_oe_n), 32'(e_oe));
      chk("we_n", 32'(sram_we_n), 32'(e_we));
      chk("oe_we_exclusive", 32'(!sram_oe_n && !sram_we_n), 32'd0);
      if (c_addr) chk("sram_addr", 32'(sram_addr), 32'(m_waddr));
      if (c_dq)   chk("sram_dq", 32'(sram_dq), 32'(m_wdata));
      if (c_cpu)  chk("cpu_rdata", 32'(cpu_data), 32'(e_cpu));
      chk("err", 32'(err), 32'(m_err));
      m_err = m_err | (cpu_re & cpu_we);
      // SRAM array behaviour: take the bus while a write strobe is active.
      if (!sram_ce_n && !sram_we_n) begin
        mem[sram_addr] = sram_dq;
        wel_cnt++;
      end
    end
  endtask

  task automatic neg();
    @(negedge clk);
    model_cmp();
  endtask

  task automatic pos();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // Leaves cpu_re high; the cycle after return is the post-DONE idle cycle.
  task automatic do_read(input logic [15:0] a, input logic [14:0] exp_waddr,
                         input logic [15:0] exp_data, input int exp_lat);
    int n;
    cpu_addr = a; cpu_re = 1'b1; cpu_we = 1'b0; n = 0;
    neg();
    while (nw && n < 20) begin
      pos(); neg(); n++;
    end
    chk("rd_latency", 32'(n), 32'(exp_lat));
    chk("rd_done_addr", 32'(sram_addr), 32'(exp_waddr));
    chk("rd_done_data", 32'(cpu_data), 32'(exp_data));
    pos();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [14:0] exp_waddr,
                          input logic [15:0] dat, input logic also_re, input int exp_lat);
    int n;
    int unsigned w0;
    w0 = wel_cnt;
    cpu_addr = a; tb_data = dat; tb_drv = 1'b1; cpu_we = 1'b1; cpu_re = also_re; n = 0;
    neg();
    while (nw && n < 20) begin
      pos(); neg(); n++;
    end
    chk("wr_latency", 32'(n), 32'(exp_lat));
    chk("wr_done_addr", 32'(sram_addr), 32'(exp_waddr));
    pos();
    cpu_we = 1'b0; cpu_re = 1'b0; tb_drv = 1'b0;
    chk("wr_we_low_cycles", 32'(wel_cnt - w0), 32'd2);
    chk("wr_mem_word", 32'(mem[exp_waddr]), 32'(dat));
  endtask

  initial begin
    int unsigned w0;
    rst_n = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000;
    tb_drv = 1'b0; tb_data = 16'h0000;
    checks = 0; errors = 0; cyc = 0; wel_cnt = 0;
    m_busy = 1'b0; m_is_wr = 1'b0; m_err = 1'b0; m_start = 0;
    m_waddr = 15'h0000; m_wdata = 16'h0000;
    mem[15'h0100] = 16'hBEEF;
    mem[15'h0000] = 16'h1111;
    mem[15'h0001] = 16'h2222;
    mem[15'h0020] = 16'h5A5A;
    #1;

    // Reset state, and the stall staying combinational under reset.
    neg(); pos();
    cpu_re = 1'b1;
    neg();
    chk("rst_stall_with_req", 32'(nw), 32'd1);
    pos();
    cpu_re = 1'b0;
    rst_n = 1'b1;
    neg(); pos();

    // Single read and single write.
    do_read(16'h0200, 15'h0100, 16'hBEEF, 3);
    cpu_re = 1'b0;
    neg(); pos();
    do_write(16'h0011, 15'h0008, 16'h1234, 1'b0, 4);
    neg(); pos();

    // Back-to-back reads with re held high.
    do_read(16'h0000, 15'h0000, 16'h1111, 3);
    do_read(16'h0002, 15'h0001, 16'h2222, 3);
    cpu_re = 1'b0;
    neg(); pos();

    // Read abort after one RD cycle.
    cpu_addr = 16'h0040; cpu_re = 1'b1;
    neg(); pos();
    neg(); pos();
    cpu_re = 1'b0;
    neg(); pos();
    neg();
    chk("abort_ce_n", 32'(sram_ce_n), 32'd1);
    chk("abort_oe_n", 32'(sram_oe_n), 32'd1);
    pos();

    // Write abort attempt: the write still completes.
    w0 = wel_cnt;
    cpu_addr = 16'h0010; tb_data = 16'h0F0F; tb_drv = 1'b1; cpu_we = 1'b1;
    neg(); pos();
    cpu_we = 1'b0; tb_drv = 1'b0;
    for (int i = 0; i < 6; i++) begin
      neg(); pos();
    end
    chk("wabort_we_low_cycles", 32'(wel_cnt - w0), 32'd2);
    chk("wabort_mem_word", 32'(mem[15'h0008]), 32'h0F0F);

    // Simultaneous re/we: write wins, err sticks until reset.
    do_write(16'h0004, 15'h0002, 16'hA5A5, 1'b1, 4);
    chk("err_set", 32'(err), 32'd1);
    neg(); pos();
    do_read(16'h0200, 15'h0100, 16'hBEEF, 3);
    cpu_re = 1'b0;
    chk("err_sticky", 32'(err), 32'd1);
    rst_n = 1'b0;
    mdl_reset();
    neg();
    chk("err_cleared", 32'(err), 32'd0);
    pos();
    rst_n = 1'b1;
    neg(); pos();

    // Asynchronous reset in the middle of a read, then a full restart.
    cpu_addr = 16'h0200; cpu_re = 1'b1;
    neg(); pos();
    neg();
    #2;
    rst_n = 1'b0;
    mdl_reset();
    #1;
    chk("arst_ce_n", 32'(sram_ce_n), 32'd1);
    chk("arst_oe_n", 32'(sram_oe_n), 32'd1);
    chk("arst_stall", 32'(nw), 32'd1);
    pos();
    rst_n = 1'b1;
    do_read(16'h0200, 15'h0100, 16'hBEEF, 3);
    cpu_re = 1'b0;
    neg(); pos();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
